uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 28 ++
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame width, FSM encoding
// and the clock-to-baud divider computation.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

  function automatic int calc_baud_ticks(input int clock_freq, input int baudrate);
    return clock_freq / baudrate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous inputs; the flops reset to RST_VAL so
// an idle-high line does not look like activity right after reset.
module uart_rx_sync #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start bit qualified at mid-bit, data and stop bits sampled
// at their centres, one-cycle rx_valid or frame_err strobe per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUDRATE   = 115200,
  parameter int CLOCK_FREQ = 27000000,
  parameter int BAUD_TICKS = calc_baud_ticks(CLOCK_FREQ, BAUDRATE),
  parameter int HALF_TICKS = BAUD_TICKS / 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy,
  output uart_state_t          o_state
);

  localparam logic [15:0] LP_BAUD_LAST = 16'(BAUD_TICKS - 1);
  localparam logic [15:0] LP_HALF_LAST = 16'(HALF_TICKS - 1);
  localparam logic [2:0]  LP_LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 w_rx_s;
  uart_state_t          r_state;
  uart_state_t          w_next_state;
  logic [15:0]          r_baud_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 w_baud_done;
  logic                 w_half_done;
  logic                 w_sample_bit;
  logic                 w_good_stop;
  logic                 w_bad_stop;

  uart_rx_sync #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk (clock),
    .i_rst (reset),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  assign w_baud_done = (r_baud_cnt == LP_BAUD_LAST);
  assign w_half_done = (r_baud_cnt == LP_HALF_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_sample_bit = 1'b0;
    w_good_stop  = 1'b0;
    w_bad_stop   = 1'b0;
    case (r_state)
      IDLE:  if (!w_rx_s) w_next_state = START;
      // A start bit that is high again at its centre was a glitch.
      START: if (w_half_done) w_next_state = w_rx_s ? IDLE : DATA;
      DATA: begin
        if (w_baud_done) begin
          w_sample_bit = 1'b1;
          if (r_bit_idx == LP_LAST_BIT) w_next_state = STOP;
        end
      end
      STOP: begin
        if (w_baud_done) begin
          if (w_rx_s) begin
            w_good_stop  = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_bad_stop   = 1'b1;
            w_next_state = BREAK;
          end
        end
      end
      // Wait out a held-low line so it cannot retrigger frames.
      BREAK: if (w_rx_s) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_baud_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data_out  <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= w_good_stop;
      r_frame_err <= w_bad_stop;

      // The counter restarts at every state change and at each data-bit sample.
      if (r_state == IDLE || w_next_state != r_state || w_sample_bit)
        r_baud_cnt <= '0;
      else
        r_baud_cnt <= r_baud_cnt + 16'd1;

      if (r_state == START && w_next_state == DATA)
        r_bit_idx <= '0;
      else if (w_sample_bit)
        r_bit_idx <= r_bit_idx + 3'd1;

      if (w_sample_bit)
        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};

      if (w_good_stop)
        r_data_out <= r_shift;
    end
  end

  assign data_out  = r_data_out;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign rx_busy   = (r_state != IDLE);
  assign o_state   = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 234 cycles/bit: frames are driven bit by bit,
// expected bytes are queued on drive and checked when rx_valid strobes.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BAUD = 234;
  localparam int HALF = 117;
  localparam int LAT  = HALF + 9 * BAUD;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx;
  logic [7:0]  data_out;
  logic        rx_valid;
  logic        frame_err;
  logic        rx_busy;
  uart_state_t o_state;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          exp_err = 0;
  logic [7:0]  last_good = 8'h00;
  int unsigned cycle = 0;
  int unsigned t_start = 0;
  int unsigned start_len = 0;
  uart_state_t prev_state = IDLE;
  logic        prev_pulse = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  uart_rx dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy),
    .o_state   (o_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic v);
    @(negedge clock);
    rx = v;
    repeat (BAUD - 1) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) begin
      exp_q.push_back(b);
      last_good = b;
    end else begin
      exp_err++;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_err != 0 || o_state != IDLE) && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk("drain_within_budget", 32'(n < 5000), 32'd1);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      prev_pulse = 1'b0;
      prev_state = IDLE;
    end else begin
      if (o_state == START && prev_state == IDLE) t_start = cycle;
      if (o_state != START && prev_state == START) start_len = cycle - t_start;
      if (rx_valid || frame_err) begin
        chk("pulse_exclusive", 32'(rx_valid & frame_err), 32'd0);
        chk("pulse_single_cycle", 32'(prev_pulse), 32'd0);
        chk("pulse_latency", cycle - t_start, LAT);
      end
      if (rx_valid) begin
        chk("rx_valid_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("rx_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
      if (frame_err) begin
        chk("frame_err_expected", 32'(exp_err != 0), 32'd1);
        if (exp_err > 0) exp_err--;
      end
      prev_pulse = rx_valid | frame_err;
      prev_state = o_state;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] b81;
    b81   = 8'h81;
    rx    = 1'b1;
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("reset_state", 32'(o_state), 32'(IDLE));
    reset = 1'b0;
    repeat (1000) @(negedge clock);
    chk("idle_data_out", 32'(data_out), 32'h00);
    chk("idle_rx_valid", 32'(rx_valid), 32'd0);
    chk("idle_frame_err", 32'(frame_err), 32'd0);
    chk("idle_rx_busy", 32'(rx_busy), 32'd0);
    chk("idle_state", 32'(o_state), 32'(IDLE));

    send_frame(8'hA5, 1'b1);
    wait_drain();
    chk("a5_data_out", 32'(data_out), 32'hA5);
    chk("a5_busy_after", 32'(rx_busy), 32'd0);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_drain();
    chk("b2b_data_out", 32'(data_out), 32'hFF);

    repeat (3) send_frame(8'($urandom_range(0, 255)), 1'b1);
    wait_drain();
    chk("random_data_out", 32'(data_out), 32'(last_good));

    // Short low glitch on an idle line.
    @(negedge clock);
    rx = 1'b0;
    repeat (50) @(negedge clock);
    rx = 1'b1;
    repeat (300) @(negedge clock);
    chk("glitch_start_len", start_len, HALF);
    chk("glitch_state", 32'(o_state), 32'(IDLE));
    chk("glitch_data_out", 32'(data_out), 32'(last_good));

    // Bad stop bit with the line held low afterwards.
    send_frame(8'h3C, 1'b0);
    repeat (2000) @(negedge clock);
    chk("break_state", 32'(o_state), 32'(BREAK));
    chk("break_busy", 32'(rx_busy), 32'd1);
    chk("break_data_out", 32'(data_out), 32'(last_good));
    chk("break_err_seen", 32'(exp_err), 32'd0);
    rx = 1'b1;
    repeat (10) @(negedge clock);
    chk("break_exit_state", 32'(o_state), 32'(IDLE));
    send_frame(8'h55, 1'b1);
    wait_drain();
    chk("after_break_data", 32'(data_out), 32'h55);

    // Reset in the middle of data bit 4 of 0x81.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b81[i]);
    @(negedge clock);
    rx = b81[4];
    repeat (100) @(negedge clock);
    chk("mid_frame_busy", 32'(rx_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midreset_state", 32'(o_state), 32'(IDLE));
    chk("midreset_busy", 32'(rx_busy), 32'd0);
    chk("midreset_data_out", 32'(data_out), 32'h00);
    chk("midreset_valid", 32'(rx_valid), 32'd0);
    rx = 1'b1;
    last_good = 8'h00;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    repeat (50) @(negedge clock);
    send_frame(8'h7E, 1'b1);
    wait_drain();
    chk("after_reset_data", 32'(data_out), 32'h7E);

    repeat (20) @(negedge clock);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
